// File: rtl/fb_pkg.sv
// Frame-buffer shared types and constants: geometry, pixel/address types,
// arbiter grant encoding and the buffered write request record.
package fb_pkg;

    localparam int HVID     = 640;
    localparam int VVID     = 480;
    localparam int FB_DEPTH = HVID * VVID;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 24;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } grant_e;

    typedef struct packed {
        fb_addr_t addr;
        pixel_t   data;
    } wr_req_t;

    // True when the linear address lands inside the visible frame.
    function automatic logic addr_in_range(input fb_addr_t a);
        return a < fb_addr_t'(FB_DEPTH);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding pending frame-buffer writes until the
// arbiter finds an idle RAM slot. Pushes while full and pops while empty
// are ignored.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_25,
    input  logic                     rst,
    input  logic                     push,
    input  wr_req_t                  din,
    input  logic                     pop,
    output wr_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_25) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares the single-port pixel RAM between the
// VGA scanout reader (absolute priority, fixed latency) and the image-load
// writer (buffered, drained in idle slots).
// Optional build macro FB_ARB_STATS_EN adds stall_cnt and max_fill outputs.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_oob,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [$clog2(WFIFO_DEPTH):0]   max_fill
`endif
);

    localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

    wr_req_t          fifo_din;
    wr_req_t          fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    grant_e           grant_d;
    grant_e           grant_q;
    logic             rd_en_q;
    fb_addr_t         addr_q;
    pixel_t           wdata_q;
    logic             oob_q;
    logic             wr_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [MEM_LAT:0] vld_pipe;
    logic [MEM_LAT:0] ok_pipe;

    // Writer handshake depends only on registered occupancy and reset.
    assign wr_ready    = !fifo_full && !rst;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = addr_in_range(wr_addr);
    assign rd_in_range = addr_in_range(rd_addr);
    assign fifo_push   = wr_fire && wr_in_range;
    assign fifo_din    = '{addr: wr_addr, data: wr_data};
    assign fifo_pop    = (grant_d == GNT_WR);

    fb_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk_25 (clk_25),
        .rst    (rst),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (fifo_pop),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Pick the next RAM owner: scanout first, then a buffered write, else idle.
    always_comb begin
        grant_d = GNT_NONE;
        if (rd_req) begin
            grant_d = GNT_RD;
        end else if (!fifo_empty) begin
            grant_d = GNT_WR;
        end
    end

    // Grant register and the registered RAM command it owns.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            grant_q <= GNT_NONE;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            grant_q <= grant_d;
            rd_en_q <= rd_req && rd_in_range;
            case (grant_d)
                GNT_RD: begin
                    addr_q  <= rd_in_range ? rd_addr : '0;
                    wdata_q <= '0;
                end
                GNT_WR: begin
                    addr_q  <= fifo_head.addr;
                    wdata_q <= fifo_head.data;
                end
                default: begin
                    addr_q  <= '0;
                    wdata_q <= '0;
                end
            endcase
        end
    end

    assign mem_we    = (grant_q == GNT_WR);
    assign mem_en    = mem_we || ((grant_q == GNT_RD) && rd_en_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Read-return delay line; ok bits mark reads that actually touched the RAM.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            vld_pipe <= '0;
            ok_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MEM_LAT-1:0], rd_req};
            ok_pipe  <= {ok_pipe[MEM_LAT-1:0], rd_req && rd_in_range};
        end
    end

    assign rd_valid = vld_pipe[MEM_LAT];
    assign rd_data  = (vld_pipe[MEM_LAT] && ok_pipe[MEM_LAT]) ? mem_rdata : '0;

    // One-cycle flag for an accepted write that fell outside the frame and was dropped.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= wr_fire && !wr_in_range;
        end
    end

    assign wr_oob = oob_q;

`ifdef FB_ARB_STATS_EN
    // Writer back-pressure cycles (saturating) and peak buffer occupancy.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            stall_cnt <= '0;
            max_fill  <= '0;
        end else begin
            if (wr_valid && !wr_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (fifo_count > max_fill) begin
                max_fill <= fifo_count;
            end
        end
    end
`endif

endmodule
